// File: rtl/sift_pkg.sv
// Shared types and constants for the image window generator.
// Holds the pixel type, the window FSM state encoding, the default geometry
// and the fixed pixel-to-window latency.
package sift_pkg;

  localparam int IMAGE_DATA_WIDTH_DEF = 8;
  localparam int CONV_KERNEL_SIZE_DEF = 11;

  // Rows held in line buffers for the default kernel edge.
  localparam int LB_COUNT_DEF = CONV_KERNEL_SIZE_DEF - 1;

  // Cycles from pixel acceptance to kvalid.
  localparam int OUT_LATENCY = 2;

  typedef logic [IMAGE_DATA_WIDTH_DEF-1:0] pix_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } win_state_t;

  // A window of edge n needs n-1 previous rows.
  function automatic int lb_count(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/image_window_gen_line_buffer.sv
// One image row of storage. Single clock, registered read-first RAM.
// A read and a write in the same cycle at the same address return the old
// word. Contents are never cleared; the window logic never trusts a word
// before the current frame has written it.
module line_buffer #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Read-first RAM port pair: the read samples the array before the write lands.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/image_window_gen.sv
// Sliding n x n window generator over a raster pixel stream.
// Optional framing check is enabled by defining WINDOW_FRAME_CHECK_EN:
// an eol/column disagreement or a sof inside a frame then pulses frame_err.
//
// Handshake: a pixel transfers on a rising clock edge where pix_valid and
// pix_ready are both 1. pix_ready is registered and only drops during reset.
// kvalid has no ready: it is a one-cycle pulse the consumer must take, and
// kernel holds its value until the next kvalid.
module image_window_gen
  import sift_pkg::*;
#(
  parameter int IMAGE_COLUMN     = 512,
  parameter int IMAGE_ROW        = 512,
  parameter int IMAGE_DATA_WIDTH = IMAGE_DATA_WIDTH_DEF,
  parameter int CONV_KERNEL_SIZE = CONV_KERNEL_SIZE_DEF
) (
  input  logic axi_clk,
  input  logic axi_rst,
  input  logic pix_valid,
  output logic pix_ready,
  input  logic [IMAGE_DATA_WIDTH-1:0] pix_data,
  input  logic pix_sof,
  input  logic pix_eol,
  output logic kvalid,
  output logic [CONV_KERNEL_SIZE-1:0][CONV_KERNEL_SIZE-1:0][IMAGE_DATA_WIDTH-1:0] kernel,
  output logic frame_done,
  output logic frame_err,
  output logic dbg_state
);

  localparam int N   = CONV_KERNEL_SIZE;
  localparam int NLB = lb_count(N);
  localparam int W   = IMAGE_DATA_WIDTH;
  localparam int CW  = $clog2(IMAGE_COLUMN);
  localparam int RW  = $clog2(IMAGE_ROW);

  localparam logic [CW-1:0] COL_LAST      = CW'(IMAGE_COLUMN - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMAGE_ROW - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(N - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(N - 1);

  win_state_t state_q, state_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic pix_ready_q, pix_ready_d;
  logic frame_done_q, frame_done_d;
  logic frame_err_q, frame_err_d;

  // Stage 1: the accepted pixel, delayed to line up with the RAM read data.
  logic s1_valid_q, s1_valid_d;
  logic s1_emit_q, s1_emit_d;
  logic [W-1:0] s1_pix_q, s1_pix_d;
  logic [CW-1:0] s1_addr_q, s1_addr_d;

  logic [N-1:0][N-1:0][W-1:0] win_q, win_d;
  logic [N-1:0][N-1:0][W-1:0] kernel_q, kernel_d;
  logic kvalid_q, kvalid_d;

  logic accept;
  logic take;
  logic err_now;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [NLB-1:0][W-1:0] lb_rd;
  logic [NLB-1:0][W-1:0] lb_wr;

  assign accept = pix_valid & pix_ready_q;

`ifndef WINDOW_FRAME_CHECK_EN
  // Geometry comes from the counters alone; eol carries no information here.
  logic unused_eol;
  assign unused_eol = pix_eol;
`endif

  // Frame FSM: decide whether the pixel enters the pipeline and advance the raster position.
  always_comb begin
    state_d      = state_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    pix_ready_d  = 1'b1;
    frame_done_d = 1'b0;
    err_now      = 1'b0;
    take         = 1'b0;
    cur_col      = pix_sof ? '0 : col_cnt_q;
    cur_row      = pix_sof ? '0 : row_cnt_q;
    if (accept) begin
      if (pix_sof) begin
        take    = 1'b1;
        state_d = ACTIVE;
`ifdef WINDOW_FRAME_CHECK_EN
        if (state_q == ACTIVE) err_now = 1'b1;
`endif
      end else if (state_q == ACTIVE) begin
`ifdef WINDOW_FRAME_CHECK_EN
        if (pix_eol != (col_cnt_q == COL_LAST)) begin
          err_now = 1'b1;
          state_d = IDLE;
        end else begin
          take = 1'b1;
        end
`else
        take = 1'b1;
`endif
      end
      if (take) begin
        if (cur_col == COL_LAST) begin
          col_cnt_d = '0;
          if (cur_row == ROW_LAST) begin
            row_cnt_d    = '0;
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            row_cnt_d = cur_row + 1'b1;
          end
        end else begin
          col_cnt_d = cur_col + 1'b1;
          row_cnt_d = cur_row;
        end
      end
    end
    frame_err_d = err_now;
  end

  // Stage 1 capture: pixel, its column address and whether it completes a full window.
  always_comb begin
    s1_valid_d = take;
    s1_emit_d  = take && (cur_row >= ROW_FIRST_WIN) && (cur_col >= COL_FIRST_WIN);
    s1_pix_d   = take ? pix_data : s1_pix_q;
    s1_addr_d  = take ? cur_col : s1_addr_q;
  end

  // Cascade writes: buffer 0 takes the new pixel, buffer k takes what buffer k-1 held.
  always_comb begin
    lb_wr[0] = s1_pix_q;
    for (int k = 1; k < NLB; k++) lb_wr[k] = lb_rd[k-1];
  end

  for (genvar k = 0; k < NLB; k++) begin : g_lb
    line_buffer #(
      .DEPTH(IMAGE_COLUMN),
      .WIDTH(W),
      .AW   (CW)
    ) u_lb (
      .clk    (axi_clk),
      .rd_en  (take),
      .rd_addr(cur_col),
      .rd_data(lb_rd[k]),
      .wr_en  (s1_valid_q),
      .wr_addr(s1_addr_q),
      .wr_data(lb_wr[k])
    );
  end

  // Window shift: newest column enters at n-1; a kernel is published for complete windows.
  always_comb begin
    win_d    = win_q;
    kernel_d = kernel_q;
    kvalid_d = 1'b0;
    if (s1_valid_q) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N - 1; c++) win_d[r][c] = win_q[r][c+1];
      end
      for (int r = 0; r < N - 1; r++) win_d[r][N-1] = lb_rd[N-2-r];
      win_d[N-1][N-1] = s1_pix_q;
      // A framing error in this cycle discards the window still in flight.
      if (s1_emit_q && !err_now) begin
        kvalid_d = 1'b1;
        kernel_d = win_d;
      end
    end
  end

  // All state, counters and registered outputs; reset discards in-flight pixels.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q      <= IDLE;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      pix_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_emit_q    <= 1'b0;
      s1_pix_q     <= '0;
      s1_addr_q    <= '0;
      win_q        <= '0;
      kernel_q     <= '0;
      kvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      pix_ready_q  <= pix_ready_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      s1_valid_q   <= s1_valid_d;
      s1_emit_q    <= s1_emit_d;
      s1_pix_q     <= s1_pix_d;
      s1_addr_q    <= s1_addr_d;
      win_q        <= win_d;
      kernel_q     <= kernel_d;
      kvalid_q     <= kvalid_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign kvalid     = kvalid_q;
  assign kernel     = kernel_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign dbg_state  = (state_q == ACTIVE);

endmodule

// File: doc/image_window_gen.md
Name: image_window_gen

Overview:
- Upstream feeder for the Gaussian convolution bank.
- Accepts a raster-order 8-bit pixel stream and stores CONV_KERNEL_SIZE-1 previous image rows in line buffers.
- Emits one full CONV_KERNEL_SIZE x CONV_KERNEL_SIZE window per accepted pixel, but only for pixels whose window lies fully inside the image.
- Output pair kvalid/kernel drives the pre-adder input of the convolution stage directly. The consumer has no backpressure.

Parameters:
- IMAGE_COLUMN, 512, pixels per row.
- IMAGE_ROW, 512, rows per frame.
- IMAGE_DATA_WIDTH, 8, bits per pixel.
- CONV_KERNEL_SIZE, 11, window edge n. Must be odd and ≥3.

Ports:
- axi_clk  in  1  single clock for all logic.
- axi_rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  input pixel present.
- pix_ready  out  1  block can accept a pixel.
- pix_data  in  IMAGE_DATA_WIDTH  pixel value.
- pix_sof  in  1  first pixel of frame (row 0, col 0).
- pix_eol  in  1  last pixel of a row.
- kvalid  out  1  kernel holds a valid window, 1-cycle pulse per window.
- kernel  out  [n][n][IMAGE_DATA_WIDTH]  window. kernel[r][c]: r=0 is the top (oldest) row, c=0 is the leftmost column. kernel[n-1][n-1] is the pixel that completed the window.
- frame_done  out  1  1-cycle pulse after the last pixel of a frame is accepted.
- frame_err  out  1  1-cycle pulse on a framing error (see Optional Feature).

Behaviour:
- Decided: one clock, axi_clk. Reset axi_rst is synchronous and active-high.
- Reset values:
  - pix_ready=0, kvalid=0, kernel=0, frame_done=0, frame_err=0.
  - Counters=0, FSM=IDLE.
  - Line-buffer RAM contents are not cleared; they are never read as valid before being rewritten.
- Transfer: a pixel is accepted when pix_valid & pix_ready.
- FSM states:
  - IDLE: pix_ready=1. Accepted pixels without pix_sof are dropped. An accepted pixel with pix_sof is processed as (row 0, col 0); go to ACTIVE.
  - ACTIVE: pix_ready=1. Each accepted pixel advances col_cnt; at IMAGE_COLUMN-1, col_cnt wraps to 0 and row_cnt increments. Acceptance of (IMAGE_ROW-1, IMAGE_COLUMN-1) pulses frame_done one cycle later and returns to IDLE.
  - An accepted pix_sof in ACTIVE restarts the frame: the pixel is processed as (0,0), there is no frame_done, and the FSM stays in ACTIVE.
- Line buffers:
  - n-1 buffers, each IMAGE_COLUMN deep and IMAGE_DATA_WIDTH wide, cascaded and addressed by col_cnt.
  - On acceptance at column c: read all buffers at address c. Buffer 0 is written with the new pixel; buffer k is written with the old content of buffer k-1.
  - Read-before-write at the same address is required.
  - RAM read latency is 1 cycle; the new pixel is delayed 1 cycle to align with it.
- Window:
  - The column vector {buf[n-2] … buf[0], pixel} shifts into a register array: column n-1 is newest, column 0 is discarded.
  - Shifting occurs only on accepted pixels; gaps in pix_valid freeze the window.
- Output rule: kvalid=1 exactly 2 cycles after accepting a pixel at (row, col) with row ≥ n-1 and col ≥ n-1.
  - kernel holds pixels rows row-n+1..row, cols col-n+1..col.
  - kernel is held until the next kvalid.
  - Windows per frame: (IMAGE_ROW-n+1)*(IMAGE_COLUMN-n+1).
- Reset mid-frame: next cycle, all outputs are at reset values and in-flight pixels are discarded. Row fill restarts from the next sof.

Optional Feature:
- Macro: WINDOW_FRAME_CHECK_EN.
- Defined:
  - In ACTIVE, an accepted pixel with pix_eol ≠ (col_cnt==IMAGE_COLUMN-1) pulses frame_err (1 cycle after acceptance) and returns to IDLE. No kvalid is generated for that pixel or its in-flight windows.
  - pix_sof in ACTIVE also pulses frame_err in addition to the restart.
- Not defined: pix_eol is ignored, frame_err is tied to 0, and the counters alone define geometry.

Decomposition:
- Package sift_pkg:
  - Pixel typedef pix_t (IMAGE_DATA_WIDTH).
  - FSM enum win_state_t {IDLE, ACTIVE}.
  - Localparams for the line-buffer count n-1 and output latency 2.
- One sub-module: line_buffer.
  - Single-clock RAM of depth IMAGE_COLUMN, registered read-first.
  - Instantiated n-1 times in a generate loop.

Test Plan:
- Parameters for these scenarios: IMAGE_COLUMN=16, IMAGE_ROW=12, n=5. Pixel value = (row*16+col)&0xFF, continuous valid.
- First window: first kvalid occurs 2 cycles after accepting (4,4). kernel[4][4]=0x44, kernel[0][0]=0x00, kernel[2][1]=0x21.
- Full frame:
  - Exactly 96 kvalid pulses.
  - Last window kernel[4][4]=0xBF and kernel[0][0]=0x7B.
  - frame_done is asserted once, 1 cycle after accepting (11,15).
- Random pix_valid gaps (~50% duty): the kvalid count and every kernel match the gap-free run; kvalid never repeats without a new pixel.
- axi_rst asserted for 1 cycle at pixel (6,3), then a new sof frame: no kvalid before (4,4) of the new frame, and the first window equals the fresh-frame golden window.
- Pixels without sof in IDLE: all dropped, with no kvalid and no frame_done.
- With WINDOW_FRAME_CHECK_EN: pix_eol asserted at (2,9) → frame_err pulse, FSM returns to IDLE, no further kvalid until the next sof. Without the macro: frame_err stays 0 and the frame completes normally.
